// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder: registered binary-to-one-hot decoder with valid/ready handshakes and up/down scan mode.
// Optional feature: define ONEHOT_DEC_ERR_EN to flag out-of-range selects on out_err.
module onehot_seq_decoder #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [SEL_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_err
);
    localparam int               CW          = $clog2(OUT_W + 1);
    localparam logic [SEL_W:0]   LP_W        = (SEL_W + 1)'(OUT_W);
    localparam logic [SEL_W-1:0] LP_MAX      = SEL_W'(OUT_W - 1);
    localparam logic [SEL_W-1:0] LP_IDX_ONE  = SEL_W'(1);
    localparam logic [CW-1:0]    LP_CNT_LAST = CW'(OUT_W);
    localparam logic [CW-1:0]    LP_CNT_ONE  = CW'(1);
    localparam logic [OUT_W-1:0] LP_ONE      = OUT_W'(1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           r_state;
    logic             r_dn;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic [OUT_W-1:0] r_onehot;
    logic [SEL_W-1:0] r_idx;
    logic             r_last;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_in_range;
    logic             w_scan_req;
    logic [SEL_W-1:0] w_idx_adv;
    logic [CW-1:0]    w_cnt_adv;

    assign in_ready   = (r_state == IDLE) && (!r_valid || out_ready);
    assign out_valid  = r_valid;
    assign out_onehot = r_onehot;
    assign out_idx    = r_idx;
    assign out_last   = r_last;

    // Handshake qualifiers and next scan index/count; wrap is explicit so non-power-of-two widths work.
    always_comb begin
        w_in_fire  = in_valid && in_ready;
        w_out_fire = r_valid && out_ready;
        w_in_range = {1'b0, in_sel} < LP_W;
        w_scan_req = (in_mode == 2'b01) || (in_mode == 2'b10);
        w_idx_adv  = r_dn ? ((r_idx == '0) ? LP_MAX : r_idx - LP_IDX_ONE)
                          : ((r_idx == LP_MAX) ? '0 : r_idx + LP_IDX_ONE);
        w_cnt_adv  = r_cnt + LP_CNT_ONE;
    end

    // Sequencer and output register: a new request loads the first beat, each consumed scan beat advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dn     <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_idx    <= '0;
            r_last   <= 1'b0;
        end else if (w_in_fire) begin
            r_valid  <= 1'b1;
            r_onehot <= w_in_range ? (LP_ONE << in_sel) : '0;
            r_idx    <= w_in_range ? in_sel : '0;
            r_last   <= !(w_in_range && w_scan_req);
            r_state  <= (w_in_range && w_scan_req) ? SCAN : IDLE;
            r_dn     <= in_mode[1];
            r_cnt    <= LP_CNT_ONE;
        end else if (w_out_fire) begin
            if (r_state == SCAN) begin
                r_idx    <= w_idx_adv;
                r_onehot <= LP_ONE << w_idx_adv;
                r_cnt    <= w_cnt_adv;
                r_last   <= (w_cnt_adv == LP_CNT_LAST);
                r_state  <= (w_cnt_adv == LP_CNT_LAST) ? IDLE : SCAN;
            end else begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

`ifdef ONEHOT_DEC_ERR_EN
    logic r_err;
    logic r_err_sticky;

    // Error beat flag follows the beat it belongs to; sticky flag records any error since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else if (w_in_fire) begin
            r_err        <= !w_in_range;
            r_err_sticky <= r_err_sticky || !w_in_range;
        end else if (w_out_fire) begin
            r_err <= 1'b0;
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif
endmodule
